// File: rtl/branch_pkg.sv
// Shared definitions for the decode-stage branch resolution controller:
// comparator mode codes, forwarding select codes, FSM states and the
// operand-usage helpers.
package branch_pkg;

  localparam logic [2:0] CMP_NONE = 3'b000;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NE   = 3'b010;
  localparam logic [2:0] CMP_GTZ  = 3'b011;
  localparam logic [2:0] CMP_GEZ  = 3'b100;
  localparam logic [2:0] CMP_LTZ  = 3'b101;
  localparam logic [2:0] CMP_LEZ  = 3'b110;
  localparam logic [2:0] CMP_GE   = 3'b111;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // rs feeds every real compare mode
  function automatic logic rs_used(input logic [2:0] mode);
    return mode != CMP_NONE;
  endfunction

  // rt only matters for the two-operand compares
  function automatic logic rt_used(input logic [2:0] mode);
    return (mode == CMP_EQ) || (mode == CMP_NE) || (mode == CMP_GE);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// D-stage branch interface between the pipeline (master) and the branch
// resolution controller (slave). With BRANCH_STATS_EN defined the
// statistics counters are carried here as extra controller outputs.
interface branch_resolve_ctrl_if;

  logic       br_valid_d;
  logic [2:0] cmp_mode_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [4:0] wa_e;
  logic [1:0] tnew_e;
  logic [4:0] wa_m;
  logic [1:0] tnew_m;
  logic       cmp_branch;

  logic       stall;
  logic [2:0] cmp_mode;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       pc_sel_branch;
  logic       in_delay_slot;
  logic       err_ds_branch;
  logic       err_timeout;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_total;
  logic [31:0] br_taken;
  logic [31:0] br_stall_cycles;
`endif

  modport master (
    output br_valid_d, cmp_mode_d, rs_d, rt_d, wa_e, tnew_e, wa_m, tnew_m,
           cmp_branch,
    input  stall, cmp_mode, fwd_rs_sel, fwd_rt_sel, pc_sel_branch,
           in_delay_slot, err_ds_branch, err_timeout
`ifdef BRANCH_STATS_EN
    , input br_total, br_taken, br_stall_cycles
`endif
  );

  modport slave (
    input  br_valid_d, cmp_mode_d, rs_d, rt_d, wa_e, tnew_e, wa_m, tnew_m,
           cmp_branch,
    output stall, cmp_mode, fwd_rs_sel, fwd_rt_sel, pc_sel_branch,
           in_delay_slot, err_ds_branch, err_timeout
`ifdef BRANCH_STATS_EN
    , output br_total, br_taken, br_stall_cycles
`endif
  );

endinterface

// File: rtl/operand_hazard_chk.sv
// Per-operand RAW check against the in-flight E and M destinations.
// E is the younger producer, so it shadows M when both write r.
module operand_hazard_chk
  import branch_pkg::*;
(
  input  logic [4:0] r,
  input  logic       used,
  input  logic [4:0] wa_e,
  input  logic [1:0] tnew_e,
  input  logic [4:0] wa_m,
  input  logic [1:0] tnew_m,
  output logic       hazard,
  output logic [1:0] fwd_sel
);

  // Hazard when the producer is not yet forwardable, else pick its stage
  always_comb begin
    hazard  = 1'b0;
    fwd_sel = FWD_RF;
    if (used && (r != 5'd0)) begin
      if (wa_e == r) begin
        if (tnew_e != 2'd0) hazard = 1'b1;
        else                fwd_sel = FWD_E;
      end else if (wa_m == r) begin
        if (tnew_m != 2'd0) hazard = 1'b1;
        else                fwd_sel = FWD_M;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch resolution controller: stalls D on comparator
// operand hazards, drives comparator mode / forwarding selects, issues
// the NPC branch select and tracks the delay slot.
// Optional: define BRANCH_STATS_EN for branch/stall statistics counters.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int STALL_CNT_W = 4,
  parameter int MAX_STALL   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_resolve_ctrl_if.slave bus
);

  localparam logic [STALL_CNT_W-1:0] MAX_STALL_C = STALL_CNT_W'(MAX_STALL);
  localparam logic [STALL_CNT_W-1:0] CNT_ONE     = STALL_CNT_W'(1);

  state_t                 state_reg, state_next;
  logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic                   ds_pending_reg, ds_pending_next;
  logic                   err_ds_reg, err_ds_next;
  logic                   err_to_reg, err_to_next;
  logic                   stall, resolve, ds_branch, any_haz;

  // index 0 = rs, index 1 = rt
  logic [4:0] op_r    [2];
  logic       op_used [2];
  logic       op_haz  [2];
  logic [1:0] op_sel  [2];

  assign op_r[0]    = bus.rs_d;
  assign op_r[1]    = bus.rt_d;
  assign op_used[0] = rs_used(bus.cmp_mode_d);
  assign op_used[1] = rt_used(bus.cmp_mode_d);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
      operand_hazard_chk u_chk (
        .r      (op_r[gi]),
        .used   (op_used[gi]),
        .wa_e   (bus.wa_e),
        .tnew_e (bus.tnew_e),
        .wa_m   (bus.wa_m),
        .tnew_m (bus.tnew_m),
        .hazard (op_haz[gi]),
        .fwd_sel(op_sel[gi])
      );
    end
  endgenerate

  assign any_haz = op_haz[0] | op_haz[1];

  // Next-state and resolve decision; a delay-slot branch is flagged, never resolved
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    resolve    = 1'b0;
    ds_branch  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.br_valid_d) begin
          if (ds_pending_reg) begin
            ds_branch = 1'b1;
          end else if (any_haz) begin
            stall      = 1'b1;
            state_next = STALL;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      STALL: begin
        if (!bus.br_valid_d) begin
          state_next = IDLE;
        end else if (any_haz) begin
          stall = 1'b1;
        end else begin
          resolve    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter, delay-slot and sticky-error next values
  always_comb begin
    stall_cnt_next = '0;
    if (stall) begin
      stall_cnt_next = (stall_cnt_reg == '1) ? stall_cnt_reg : stall_cnt_reg + CNT_ONE;
    end
    ds_pending_next = resolve ? 1'b1 : (stall ? ds_pending_reg : 1'b0);
    err_ds_next     = err_ds_reg | ds_branch;
    err_to_next     = err_to_reg | (stall && (stall_cnt_next >= MAX_STALL_C));
  end

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      stall_cnt_reg  <= '0;
      ds_pending_reg <= 1'b0;
      err_ds_reg     <= 1'b0;
      err_to_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stall_cnt_reg  <= stall_cnt_next;
      ds_pending_reg <= ds_pending_next;
      err_ds_reg     <= err_ds_next;
      err_to_reg     <= err_to_next;
    end
  end

  assign bus.stall         = stall;
  assign bus.cmp_mode      = resolve ? bus.cmp_mode_d : CMP_NONE;
  assign bus.pc_sel_branch = resolve & bus.cmp_branch;
  assign bus.fwd_rs_sel    = op_sel[0];
  assign bus.fwd_rt_sel    = op_sel[1];
  assign bus.in_delay_slot = ds_pending_reg;
  assign bus.err_ds_branch = err_ds_reg;
  assign bus.err_timeout   = err_to_reg;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_total_reg, br_taken_reg, br_stall_cycles_reg;

  // Wrapping statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      br_total_reg        <= '0;
      br_taken_reg        <= '0;
      br_stall_cycles_reg <= '0;
    end else begin
      if (resolve)                  br_total_reg        <= br_total_reg + 32'd1;
      if (resolve && bus.cmp_branch) br_taken_reg       <= br_taken_reg + 32'd1;
      if (stall)                    br_stall_cycles_reg <= br_stall_cycles_reg + 32'd1;
    end
  end

  assign bus.br_total        = br_total_reg;
  assign bus.br_taken        = br_taken_reg;
  assign bus.br_stall_cycles = br_stall_cycles_reg;
`endif

endmodule
